// File: rtl/cpu_pkg.sv
// Shared definitions for the one-bus CPU control path: opcodes, sequencer
// states and instruction classes.
package cpu_pkg;

    localparam int unsigned OPC_WIDTH = 5;
    localparam int unsigned IR_W      = 32;

    localparam logic [OPC_WIDTH-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_WIDTH-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_WIDTH-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_WIDTH-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_WIDTH-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_WIDTH-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_WIDTH-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPC_WIDTH-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_WIDTH-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_WIDTH-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_WIDTH-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_WIDTH-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_WIDTH-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_WIDTH-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_WIDTH-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPC_WIDTH-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_WIDTH-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPC_WIDTH-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPC_WIDTH-1:0] OP_BR   = 5'b10010;
    localparam logic [OPC_WIDTH-1:0] OP_JR   = 5'b10011;
    localparam logic [OPC_WIDTH-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPC_WIDTH-1:0] OP_IN   = 5'b10101;
    localparam logic [OPC_WIDTH-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPC_WIDTH-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPC_WIDTH-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPC_WIDTH-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPC_WIDTH-1:0] OP_HALT = 5'b11010;

    // T0..T7 are contiguous so a step advance is a simple increment.
    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9,
        S_WAIT  = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU3,
        CL_IMM,
        CL_UNARY,
        CL_MULDIV,
        CL_LD,
        CL_LDI,
        CL_ST,
        CL_BR,
        CL_JR,
        CL_JAL,
        CL_IN,
        CL_OUT,
        CL_MFHI,
        CL_MFLO,
        CL_NOP,
        CL_HALT
    } iclass_t;

    // Next micro-step within an instruction; saturates at T7.
    function automatic state_t next_step(input state_t s);
        state_t n;
        case (s)
            S_T0:    n = S_T1;
            S_T1:    n = S_T2;
            S_T2:    n = S_T3;
            S_T3:    n = S_T4;
            S_T4:    n = S_T5;
            S_T5:    n = S_T6;
            S_T6:    n = S_T7;
            default: n = S_T7;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode to instruction class, and class to final execute step.
module cu_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode_i,
    output iclass_t          class_o,
    output state_t           last_o
);

    // Classify the opcode; anything undefined behaves as nop.
    always_comb begin
        class_o = CL_NOP;
        case (opcode_i)
            OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_SHR), OPC_W'(OP_SHL),
            OPC_W'(OP_ROR), OPC_W'(OP_ROL), OPC_W'(OP_AND), OPC_W'(OP_OR):
                class_o = CL_ALU3;
            OPC_W'(OP_ADDI), OPC_W'(OP_ANDI), OPC_W'(OP_ORI):
                class_o = CL_IMM;
            OPC_W'(OP_NEG), OPC_W'(OP_NOT):  class_o = CL_UNARY;
            OPC_W'(OP_MUL), OPC_W'(OP_DIV):  class_o = CL_MULDIV;
            OPC_W'(OP_LD):                   class_o = CL_LD;
            OPC_W'(OP_LDI):                  class_o = CL_LDI;
            OPC_W'(OP_ST):                   class_o = CL_ST;
            OPC_W'(OP_BR):                   class_o = CL_BR;
            OPC_W'(OP_JR):                   class_o = CL_JR;
            OPC_W'(OP_JAL):                  class_o = CL_JAL;
            OPC_W'(OP_IN):                   class_o = CL_IN;
            OPC_W'(OP_OUT):                  class_o = CL_OUT;
            OPC_W'(OP_MFHI):                 class_o = CL_MFHI;
            OPC_W'(OP_MFLO):                 class_o = CL_MFLO;
            OPC_W'(OP_HALT):                 class_o = CL_HALT;
            default:                         class_o = CL_NOP;
        endcase
    end

    // Last execute step of each class (instruction length minus one).
    always_comb begin
        last_o = S_T3;
        case (class_o)
            CL_ALU3, CL_IMM, CL_LDI: last_o = S_T5;
            CL_UNARY, CL_JAL:        last_o = S_T4;
            CL_MULDIV, CL_BR:        last_o = S_T6;
            CL_LD, CL_ST:            last_o = S_T7;
            default:                 last_o = S_T3;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the one-bus CPU: fetch T0-T2, execute T3-T7.
// Build option CU_STEP_EN adds a Step input and a WAIT state at every
// instruction boundary for single-stepping.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [IR_W-1:0] IR,
    input  logic            CON_FF,
    input  logic            Stop,
`ifdef CU_STEP_EN
    input  logic            Step,
`endif
    output logic            PCout,
    output logic            PC_enable,
    output logic            IncPC,
    output logic            MAR_enable,
    output logic            MDR_enable,
    output logic            MDR_read,
    output logic            MDRout,
    output logic            RAM_write,
    output logic            IR_enable,
    output logic            Y_enable,
    output logic            ZLowIn,
    output logic            ZHighIn,
    output logic            ZLowout,
    output logic            ZHighout,
    output logic            HI_enable,
    output logic            LO_enable,
    output logic            HIout,
    output logic            LOout,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            R_in,
    output logic            R_out,
    output logic            BAout,
    output logic            Cout,
    output logic            CONin,
    output logic            InPortout,
    output logic            OutPort_enable,
    output logic            Run
);

`ifdef CU_STEP_EN
    localparam state_t BOUNDARY = S_WAIT;
`else
    localparam state_t BOUNDARY = S_T0;
`endif

    state_t             state_q, state_d;
    iclass_t            iclass;
    state_t             last_step;
    logic [OPC_W-1:0]   opcode;
    logic               unused_ir;

    assign opcode    = IR[IR_W-1 -: OPC_W];
    assign unused_ir = ^IR[IR_W-1-OPC_W:0];

    cu_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode_i (opcode),
        .class_o  (iclass),
        .last_o   (last_step)
    );

    // State register; Clear drops straight to RESET.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // Next-state: fetch, execute until the class's last step, then boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0, S_T1, S_T2: state_d = next_step(state_q);
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (iclass == CL_HALT)       state_d = S_HALT;
                else if (state_q >= last_step) state_d = Stop ? S_HALT : BOUNDARY;
                else                         state_d = next_step(state_q);
            end
            S_HALT: state_d = S_HALT;
`ifdef CU_STEP_EN
            S_WAIT: begin
                if (Stop)      state_d = S_HALT;
                else if (Step) state_d = S_T0;
                else           state_d = S_WAIT;
            end
`endif
            default: state_d = S_RESET;
        endcase
    end

    // Strobe decode from the current step, instruction class and CON_FF.
    always_comb begin
        PCout = 1'b0; PC_enable = 1'b0; IncPC = 1'b0;
        MAR_enable = 1'b0; MDR_enable = 1'b0; MDR_read = 1'b0;
        MDRout = 1'b0; RAM_write = 1'b0; IR_enable = 1'b0;
        Y_enable = 1'b0; ZLowIn = 1'b0; ZHighIn = 1'b0;
        ZLowout = 1'b0; ZHighout = 1'b0; HI_enable = 1'b0;
        LO_enable = 1'b0; HIout = 1'b0; LOout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0;
        BAout = 1'b0; Cout = 1'b0; CONin = 1'b0;
        InPortout = 1'b0; OutPort_enable = 1'b0;
        Run = 1'b0;

        case (state_q)
            S_T0: begin
                Run = 1'b1;
                PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
            end
            S_T1: begin
                Run = 1'b1;
                ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1;
            end
            S_T2: begin
                Run = 1'b1;
                MDRout = 1'b1; IR_enable = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                case (iclass)
                    CL_ALU3, CL_IMM: begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    CL_UNARY:        begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
                    CL_MULDIV:       begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    CL_LD, CL_LDI, CL_ST:
                                     begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
                    CL_BR:           begin Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; end
                    CL_JR:           begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    CL_JAL:          begin PCout = 1'b1; Grb = 1'b1; R_in = 1'b1; end
                    CL_IN:           begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_OUT:          begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; end
                    CL_MFHI:         begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_MFLO:         begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                Run = 1'b1;
                case (iclass)
                    CL_ALU3:   begin Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
                    CL_IMM, CL_LD, CL_LDI, CL_ST:
                               begin Cout = 1'b1; ZLowIn = 1'b1; end
                    CL_UNARY:  begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_MULDIV: begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; end
                    CL_BR:     begin PCout = 1'b1; Y_enable = 1'b1; end
                    CL_JAL:    begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                Run = 1'b1;
                case (iclass)
                    CL_ALU3, CL_IMM, CL_LDI:
                               begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_MULDIV: begin ZLowout = 1'b1; LO_enable = 1'b1; end
                    CL_LD, CL_ST:
                               begin ZLowout = 1'b1; MAR_enable = 1'b1; end
                    CL_BR:     begin Cout = 1'b1; ZLowIn = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                Run = 1'b1;
                case (iclass)
                    CL_MULDIV: begin ZHighout = 1'b1; HI_enable = 1'b1; end
                    CL_LD:     begin MDR_read = 1'b1; MDR_enable = 1'b1; end
                    CL_ST:     begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
                    CL_BR:     begin ZLowout = 1'b1; PC_enable = CON_FF; end
                    default: ;
                endcase
            end
            S_T7: begin
                Run = 1'b1;
                case (iclass)
                    CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_ST:   RAM_write = 1'b1;
                    default: ;
                endcase
            end
            S_WAIT:  Run = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction strobe patterns cycle by cycle.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;
    logic PCout, PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, MDRout, RAM_write;
    logic IR_enable, Y_enable, ZLowIn, ZHighIn, ZLowout, ZHighout;
    logic HI_enable, LO_enable, HIout, LOout;
    logic Gra, Grb, Grc, R_in, R_out, BAout, Cout;
    logic CONin, InPortout, OutPort_enable, Run;

    int n_checks = 0;
    int n_fail   = 0;

    // Bit map of the observed output vector.
    localparam logic [28:0] PCO  = 29'd1 << 0;
    localparam logic [28:0] PCE  = 29'd1 << 1;
    localparam logic [28:0] INC  = 29'd1 << 2;
    localparam logic [28:0] MAR  = 29'd1 << 3;
    localparam logic [28:0] MDRE = 29'd1 << 4;
    localparam logic [28:0] MDRR = 29'd1 << 5;
    localparam logic [28:0] MDRO = 29'd1 << 6;
    localparam logic [28:0] RAMW = 29'd1 << 7;
    localparam logic [28:0] IRE  = 29'd1 << 8;
    localparam logic [28:0] YEN  = 29'd1 << 9;
    localparam logic [28:0] ZLI  = 29'd1 << 10;
    localparam logic [28:0] ZHI  = 29'd1 << 11;
    localparam logic [28:0] ZLO  = 29'd1 << 12;
    localparam logic [28:0] ZHO  = 29'd1 << 13;
    localparam logic [28:0] HIE  = 29'd1 << 14;
    localparam logic [28:0] LOE  = 29'd1 << 15;
    localparam logic [28:0] HIO  = 29'd1 << 16;
    localparam logic [28:0] LOO  = 29'd1 << 17;
    localparam logic [28:0] GRA  = 29'd1 << 18;
    localparam logic [28:0] GRB  = 29'd1 << 19;
    localparam logic [28:0] GRC  = 29'd1 << 20;
    localparam logic [28:0] RIN  = 29'd1 << 21;
    localparam logic [28:0] ROUT = 29'd1 << 22;
    localparam logic [28:0] BAO  = 29'd1 << 23;
    localparam logic [28:0] COUT = 29'd1 << 24;
    localparam logic [28:0] CONI = 29'd1 << 25;
    localparam logic [28:0] INP  = 29'd1 << 26;
    localparam logic [28:0] OPE  = 29'd1 << 27;
    localparam logic [28:0] RUN  = 29'd1 << 28;

    localparam logic [28:0] F0 = RUN | PCO | MAR | INC | ZLI;
    localparam logic [28:0] F1 = RUN | ZLO | PCE | MDRR | MDRE;
    localparam logic [28:0] F2 = RUN | MDRO | IRE;

    logic [28:0] outs;
    assign outs = {Run, OutPort_enable, InPortout, CONin, Cout, BAout, R_out, R_in,
                   Grc, Grb, Gra, LOout, HIout, LO_enable, HI_enable, ZHighout,
                   ZLowout, ZHighIn, ZLowIn, Y_enable, IR_enable, RAM_write, MDRout,
                   MDR_read, MDR_enable, MAR_enable, IncPC, PC_enable, PCout};

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
`ifdef CU_STEP_EN
        .Step(1'b1),
`endif
        .PCout(PCout), .PC_enable(PC_enable), .IncPC(IncPC),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .MDR_read(MDR_read),
        .MDRout(MDRout), .RAM_write(RAM_write), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .ZLowout(ZLowout), .ZHighout(ZHighout), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .HIout(HIout), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out),
        .BAout(BAout), .Cout(Cout), .CONin(CONin), .InPortout(InPortout),
        .OutPort_enable(OutPort_enable), .Run(Run)
    );

    always #5 Clock = ~Clock;

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Clear = 1'b0; Stop = 1'b0; CON_FF = 1'b0; IR = 32'h59080002;
        @(negedge Clock);
        n_checks++;
        if (outs !== 29'd0) begin n_fail++; $display("FAIL reset_hold0: got %h exp %h", outs, 29'd0); end
        step();
        n_checks++;
        if (outs !== 29'd0) begin n_fail++; $display("FAIL reset_hold1: got %h exp %h", outs, 29'd0); end
        Clear = 1'b1;
        #1;
        n_checks++;
        if (outs !== 29'd0) begin n_fail++; $display("FAIL reset_release: got %h exp %h", outs, 29'd0); end
        @(negedge Clock);
        n_checks++;
        if (outs !== F0) begin n_fail++; $display("FAIL reset_t0: got %h exp %h", outs, F0); end
    endtask

    task automatic test_addi();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | GRB | ROUT | YEN; e[4] = RUN | COUT | ZLI; e[5] = RUN | ZLO | GRA | RIN;
        IR = 32'h59080002;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL addi_t%0d: got %h exp %h", i, outs, e[i]); end
        end
        step();
        n_checks++;
        if (outs !== F0) begin n_fail++; $display("FAIL addi_back_t0: got %h exp %h", outs, F0); end
    endtask

    task automatic test_jal();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | PCO | GRB | RIN; e[4] = RUN | GRA | ROUT | PCE;
        IR = 32'hA0800000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL jal_t%0d: got %h exp %h", i, outs, e[i]); end
        end
        step();
    endtask

    task automatic test_br(input logic con);
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | GRA | ROUT | CONI; e[4] = RUN | PCO | YEN; e[5] = RUN | COUT | ZLI;
        e[6] = RUN | ZLO | (con ? PCE : 29'd0);
        IR = 32'h90000000; CON_FF = con;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL br%0d_t%0d: got %h exp %h", con, i, outs, e[i]); end
        end
        step();
        n_checks++;
        if (outs !== F0) begin n_fail++; $display("FAIL br%0d_back_t0: got %h exp %h", con, outs, F0); end
        CON_FF = 1'b0;
    endtask

    task automatic test_alu3();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | GRB | ROUT | YEN; e[4] = RUN | GRC | ROUT | ZLI; e[5] = RUN | ZLO | GRA | RIN;
        IR = 32'h18000000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL add_t%0d: got %h exp %h", i, outs, e[i]); end
        end
        step();
    endtask

    task automatic test_mul();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | GRA | ROUT | YEN; e[4] = RUN | GRB | ROUT | ZLI | ZHI;
        e[5] = RUN | ZLO | LOE; e[6] = RUN | ZHO | HIE;
        IR = 32'h70000000;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL mul_t%0d: got %h exp %h", i, outs, e[i]); end
        end
        step();
    endtask

    task automatic test_neg();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | GRB | ROUT | ZLI; e[4] = RUN | ZLO | GRA | RIN;
        IR = 32'h80000000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL neg_t%0d: got %h exp %h", i, outs, e[i]); end
        end
        step();
    endtask

    // Four-cycle instructions: jr, in, out, mfhi, mflo, nop, undefined.
    task automatic test_short_ops();
        logic [4:0]  ops [7];
        logic [28:0] t3 [7];
        ops[0] = 5'b10011; t3[0] = RUN | GRA | ROUT | PCE;
        ops[1] = 5'b10101; t3[1] = RUN | INP | GRA | RIN;
        ops[2] = 5'b10110; t3[2] = RUN | GRA | ROUT | OPE;
        ops[3] = 5'b10111; t3[3] = RUN | HIO | GRA | RIN;
        ops[4] = 5'b11000; t3[4] = RUN | LOO | GRA | RIN;
        ops[5] = 5'b11001; t3[5] = RUN;
        ops[6] = 5'b11111; t3[6] = RUN;
        for (int k = 0; k < 7; k++) begin
            IR = {ops[k], 27'h0};
            step(); step(); step();
            n_checks++;
            if (outs !== t3[k]) begin n_fail++; $display("FAIL short_op%0d_t3: got %h exp %h", k, outs, t3[k]); end
            step();
            n_checks++;
            if (outs !== F0) begin n_fail++; $display("FAIL short_op%0d_back_t0: got %h exp %h", k, outs, F0); end
        end
    endtask

    task automatic test_st_clear();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | GRB | BAO | YEN; e[4] = RUN | COUT | ZLI; e[5] = RUN | ZLO | MAR;
        e[6] = RUN | GRA | ROUT | MDRE; e[7] = RUN | RAMW;
        IR = 32'h10000000;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL st_t%0d: got %h exp %h", i, outs, e[i]); end
        end
        Clear = 1'b0;
        #1;
        n_checks++;
        if (outs !== 29'd0) begin n_fail++; $display("FAIL st_async_clear: got %h exp %h", outs, 29'd0); end
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        n_checks++;
        if (outs !== F0) begin n_fail++; $display("FAIL st_restart_t0: got %h exp %h", outs, F0); end
    endtask

    task automatic test_stop_ld();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2;
        e[3] = RUN | GRB | BAO | YEN; e[4] = RUN | COUT | ZLI; e[5] = RUN | ZLO | MAR;
        e[6] = RUN | MDRR | MDRE; e[7] = RUN | MDRO | GRA | RIN;
        IR = 32'h00000000;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL ld_stop_t%0d: got %h exp %h", i, outs, e[i]); end
            if (i == 4) Stop = 1'b1;
        end
        step();
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (outs !== 29'd0) begin n_fail++; $display("FAIL ld_stop_halt%0d: got %h exp %h", i, outs, 29'd0); end
            step();
        end
        Clear = 1'b0;
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        n_checks++;
        if (outs !== F0) begin n_fail++; $display("FAIL ld_stop_restart: got %h exp %h", outs, F0); end
    endtask

    task automatic test_halt();
        logic [28:0] e [8];
        e[0] = F0; e[1] = F1; e[2] = F2; e[3] = RUN;
        IR = 32'hD0000000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_checks++;
            if (outs !== e[i]) begin n_fail++; $display("FAIL halt_t%0d: got %h exp %h", i, outs, e[i]); end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (outs !== 29'd0) begin n_fail++; $display("FAIL halt_hold%0d: got %h exp %h", i, outs, 29'd0); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_jal();
        test_br(1'b1);
        test_br(1'b0);
        test_alu3();
        test_mul();
        test_neg();
        test_short_ops();
        test_st_clear();
        test_stop_ld();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
